// File: rtl/slow_mem_pkg.sv
// Shared definitions for the multi-cycle line memory model: default geometry,
// default latency and the transaction state encoding.
package slow_mem_pkg;

    localparam int D_MEM_WIDTH = 128;
    localparam int D_MEM_NUM   = 256;
    localparam int D_ADDR_W    = 28;
    localparam int D_LATENCY   = 15;

    // Line-index width for the default depth.
    localparam int D_IDX_W     = $clog2(D_MEM_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/slow_mem_model.sv
// Fixed-latency line memory standing in for off-chip DRAM.
// A request is latched in IDLE, counted out in WAIT and completed with a
// one-cycle o_mem_ready pulse. The array `mem` is never reset so that a
// preload done before or during reset survives.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no transaction; a read or write request is accepted here
//   WAIT  | latency countdown; a dropped request aborts back to IDLE
//   READY | completion cycle, o_mem_ready high; always back to IDLE
module slow_mem_model
    import slow_mem_pkg::*;
#(
    parameter int MEM_WIDTH = D_MEM_WIDTH,
    parameter int MEM_NUM   = D_MEM_NUM,
    parameter int ADDR_W    = D_ADDR_W,
    parameter int LATENCY   = D_LATENCY
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [ADDR_W-1:0]    i_mem_addr,
    input  logic [MEM_WIDTH-1:0] i_mem_wdata,
    output logic [MEM_WIDTH-1:0] o_mem_rdata,
    output logic                 o_mem_ready
);

    localparam int IDX_W = $clog2(MEM_NUM);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    logic [MEM_WIDTH-1:0] mem [0:MEM_NUM-1];

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [MEM_WIDTH-1:0] r_wdata;
    logic                 r_is_write;
    logic [MEM_WIDTH-1:0] r_rdata;
    logic                 r_ready;

    logic                 w_req;
    logic                 w_done;
    logic                 w_unused_addr;

    assign w_req  = i_mem_read | i_mem_write;
    // The final WAIT edge with the request still held completes the transaction.
    assign w_done = (r_state == WAIT) && w_req && (r_cnt == LAST_CNT);

    // Upper address bits alias onto the same lines.
    assign w_unused_addr = ^i_mem_addr[ADDR_W-1:IDX_W];

    assign o_mem_rdata = r_rdata;
    assign o_mem_ready = r_ready;

    // Transaction FSM with inline latency counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx      <= i_mem_addr[IDX_W-1:0];
                        r_wdata    <= i_mem_wdata;
                        r_is_write <= i_mem_write;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= READY;
                        if (!r_is_write) begin
                            r_rdata <= mem[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                READY: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Line write on completion of a write transaction; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_done && r_is_write) begin
            mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_slow_mem_model.sv
// Directed bench for slow_mem_model: a scoreboard queue holds the expected
// completion edge and read data of every transaction that should finish,
// and a negedge monitor pops and compares it when o_mem_ready shows.
module tb_slow_mem_model;

    localparam int LAT = 15;

    typedef struct {
        logic [127:0] rdata;
        int           edge_no;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic         m2_read;
    logic         m2_write;
    logic [27:0]  m2_addr;
    logic [127:0] m2_wdata;
    logic [127:0] m2_rdata;
    logic         m2_ready;

    int           cyc;
    int           n_checks;
    int           n_pass;
    exp_t         q[$];
    logic [127:0] model_mem [0:255];
    logic [127:0] model_rdata;

    slow_mem_model dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_read  (mem_read),
        .i_mem_write (mem_write),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .o_mem_rdata (mem_rdata),
        .o_mem_ready (mem_ready)
    );

    slow_mem_model #(.LATENCY(2)) dut2 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_read  (m2_read),
        .i_mem_write (m2_write),
        .i_mem_addr  (m2_addr),
        .i_mem_wdata (m2_wdata),
        .o_mem_rdata (m2_rdata),
        .o_mem_ready (m2_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the LATENCY=15 instance.
    always @(negedge clk) begin
        if (q.size() > 0 && cyc == q[0].edge_no) begin
            check("ready_on_time", {127'd0, mem_ready}, 128'd1);
            check("rdata", mem_rdata, q[0].rdata);
            void'(q.pop_front());
        end else if (mem_ready) begin
            check("spurious_ready", {127'd0, mem_ready}, 128'd0);
        end
    end

    // One transaction on the main instance, held until ready is seen.
    task automatic txn(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] wd);
        logic [127:0] exp;
        int           k;
        @(negedge clk);
        exp = wr ? model_rdata : model_mem[a[7:0]];
        k   = cyc + 1;
        q.push_back('{exp, k + LAT - 1});
        if (wr) model_mem[a[7:0]] = wd;
        else    model_rdata       = exp;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            if (mem_ready) break;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic         seen;
        logic [127:0] pre5;
        logic [127:0] pre9;
        logic [127:0] pre21;

        cyc       = 0;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        m2_read   = 1'b0;
        m2_write  = 1'b0;
        m2_addr   = '0;
        m2_wdata  = '0;
        model_rdata = '0;

        pre5  = 128'h0123456789ABCDEF0123456789ABCDEF;
        pre9  = 128'h99990000_11112222_33334444_55556666;
        pre21 = 128'hDEADBEEF_CAFEF00D_00000021_FEEDFACE;
        dut.mem[5]    = pre5;
        dut.mem[9]    = pre9;
        dut.mem[21]   = pre21;
        model_mem[5]  = pre5;
        model_mem[9]  = pre9;
        model_mem[21] = pre21;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {127'd0, mem_ready}, 128'd0);
        check("reset_rdata", mem_rdata, 128'd0);

        // Preloaded line, then write / read-back, then aliasing.
        txn(1'b1, 1'b0, 28'h5,   128'h0);
        txn(1'b0, 1'b1, 28'h3,   {16{8'hA5}});
        txn(1'b1, 1'b0, 28'h3,   128'h0);
        txn(1'b0, 1'b1, 28'h103, {16{8'h5A}});
        txn(1'b1, 1'b0, 28'h003, 128'h0);

        // Abort: request dropped after 5 cycles never completes.
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 28'd20;
        repeat (5) @(negedge clk);
        mem_read = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        check("abort_no_ready", {127'd0, seen}, 128'd0);
        txn(1'b1, 1'b0, 28'd21, 128'h0);

        // Reset during the 8th WAIT cycle of a write discards it.
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'd9;
        mem_wdata = {4{32'h12345678}};
        repeat (8) @(negedge clk);
        rst = 1'b1;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
        check("rst_mid_ready", {127'd0, mem_ready}, 128'd0);
        check("rst_mid_rdata", mem_rdata, 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        check("rst_no_ready", {127'd0, seen}, 128'd0);
        txn(1'b1, 1'b0, 28'd9, 128'h0);

        // LATENCY=2 instance: read+write on line 7 acts as a write.
        @(negedge clk);
        m2_read  = 1'b1;
        m2_write = 1'b1;
        m2_addr  = 28'd7;
        m2_wdata = 128'd1;
        @(negedge clk);
        check("l2_wr_early", {127'd0, m2_ready}, 128'd0);
        @(negedge clk);
        check("l2_wr_ready", {127'd0, m2_ready}, 128'd1);
        check("l2_wr_rdata", m2_rdata, 128'd0);
        m2_read  = 1'b0;
        m2_write = 1'b0;
        @(negedge clk);
        check("l2_wr_pulse", {127'd0, m2_ready}, 128'd0);
        m2_read = 1'b1;
        m2_addr = 28'd7;
        @(negedge clk);
        check("l2_rd_early", {127'd0, m2_ready}, 128'd0);
        @(negedge clk);
        check("l2_rd_ready", {127'd0, m2_ready}, 128'd1);
        check("l2_rd_rdata", m2_rdata, 128'd1);
        m2_read = 1'b0;
        @(negedge clk);
        check("l2_rd_pulse", {127'd0, m2_ready}, 128'd0);

        repeat (5) @(negedge clk);
        check("queue_drained", 128'(q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/slow_mem_model.md
Name: slow_mem_model

Overview:
- Behavioural multi-cycle line memory standing in for off-chip DRAM.
- Two instances sit beside CHIP: one for data, one for instructions. Both serve 128-bit cache-line refills and write-backs from the L1/L2 caches.
- Fixed-latency request/ready handshake; contents are preloadable by $readmemb/$readmemh through the internal array `mem`.

Parameters:
- MEM_WIDTH, 128, line width in bits.
- MEM_NUM, 256, number of lines in array `mem[0:MEM_NUM-1]`; power of two.
- ADDR_W, 28, line-address width (byte address bits [31:4]).
- LATENCY, 15, cycles from request acceptance to mem_ready; minimum 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high; CHIP-level rst_n is inverted at integration.
- mem_read  in  1  line read request; held until mem_ready.
- mem_write  in  1  line write request; held until mem_ready.
- mem_addr  in  ADDR_W  line address.
- mem_wdata  in  MEM_WIDTH  write line data.
- mem_rdata  out  MEM_WIDTH  read line data, registered.
- mem_ready  out  1  one-cycle completion pulse, registered.

Behaviour:
- Storage:
  - reg array `mem[0:MEM_NUM-1]` of MEM_WIDTH bits, hierarchical name exactly `mem`.
  - Never cleared by rst, so preload before or during reset survives.
  - Index = mem_addr[log2(MEM_NUM)-1:0]; upper address bits are ignored (aliasing wrap).
- FSM states:
  - IDLE: mem_ready=0. If mem_read|mem_write is sampled at edge k: latch addr, wdata, op (write wins if both high); cnt=1; go WAIT.
  - WAIT: cnt increments each edge. If the request (read|write) is sampled low, abort: go IDLE, no write, no ready. When cnt==LATENCY-1 at an edge, go READY and assert mem_ready.
  - READY: mem_ready=1 for exactly this one cycle (the cycle following edge k+LATENCY-1, i.e. visible LATENCY cycles after acceptance). Always go IDLE at the next edge.
- Data paths:
  - On entering READY for a read: mem_rdata <= mem[latched index].
  - On entering READY for a write: mem[latched index] <= latched wdata; mem_rdata unchanged.
  - mem_rdata holds its last value otherwise; it is valid at least while mem_ready=1.
- Back-to-back:
  - Requester drops its request on the edge that samples mem_ready.
  - A request high in the IDLE cycle after READY starts a new transaction. No request is ever accepted in READY.
- Read-after-write to the same line returns the newly written data.
- Inputs changing during WAIT are ignored except for the abort check; latched values are used.
- Reset (any state, including mid-transaction): state=IDLE, cnt=0, mem_ready=0, mem_rdata=0; the pending write is discarded; mem is untouched.
- Simultaneous read+write: treated as write; no read data is returned.

Decomposition:
- Shared package slow_mem_pkg holds:
  - MEM_WIDTH/MEM_NUM/ADDR_W/LATENCY defaults;
  - state enum {IDLE, WAIT, READY};
  - an index-width localparam derived via $clog2(MEM_NUM).
- Single module; the latency counter is inline, no sub-module needed.

Test Plan:
- Preload mem[5]=128'h0123...CDEF via $readmemh, rst high 2 cycles, then mem_read=1, mem_addr=5 -> mem_ready high exactly at acceptance+15 cycles for 1 cycle; mem_rdata=preloaded value; ready low at all other times.
- Write mem_addr=28'h3, wdata=128'hA5 repeated, hold until ready; then read addr 3 -> second read returns 128'hA5...A5; total 2×15 cycles plus gap cycles.
- Alias: write addr 28'h103 (MEM_NUM=256) then read addr 28'h003 -> same data returned.
- Abort: mem_read asserted 5 cycles then dropped -> no mem_ready pulse ever; a following read to another line completes normally after 15 cycles.
- Reset mid-write at cycle 8 of WAIT -> mem_ready stays 0, mem_rdata=0, target line keeps old contents; a subsequent read returns the old value.
- Read+write both high on addr 7 with wdata=1 -> treated as write; mem[7]=1, mem_rdata unchanged; LATENCY=2 override gives ready 2 cycles after acceptance.
